// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: Zicsr funct3 codes,
// access FSM states and a small funct3 decode helper.
package csr_access_unit_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // funct3 000 and 100 are not Zicsr encodings.
  function automatic logic f3_is_illegal(input logic [2:0] f3);
    return (f3[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/csr_access_unit_rmw_alu.sv
// Read-modify-write datapath for Zicsr instructions: selects the operand,
// computes the new CSR value and decides whether a read and/or write is
// architecturally required.
module csr_rmw_alu
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rd_idx,
  input  logic [XLEN-1:0] old_value,
  output logic [XLEN-1:0] new_value,
  output logic            do_read,
  output logic            do_write
);

  logic            is_swap;
  logic [XLEN-1:0] operand;

  // Swap forms skip the read when rd is x0; set/clear forms skip the write
  // when the source (x0 or zimm 0) cannot change anything.
  always_comb begin
    is_swap  = (funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI);
    operand  = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_value;
    do_read  = !(is_swap && (rd_idx == 5'd0));
    do_write = is_swap || (rs1_idx != 5'd0);
    case (funct3)
      F3_CSRRW, F3_CSRRWI: new_value = operand;
      F3_CSRRS, F3_CSRRSI: new_value = old_value | operand;
      F3_CSRRC, F3_CSRRCI: new_value = old_value & ~operand;
      default:             new_value = '0;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR access interface. Takes one decoded Zicsr
// instruction, performs the read-modify-write against the csr block and
// returns the old value (or an illegal-instruction exception).
// Build option: define CSR_ACCESS_ROCHECK_EN to reject writes to the
// read-only CSR space (csr_num[11:10] == 2'b11) before any strobe is issued.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a request; request fields latched on accept
// ST_READ  | read_csr strobe, old value captured from read_value
// ST_WRITE | write_csr strobe with the computed new value
// ST_RESP  | response held on rsp_* until writeback takes it
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [CSR_AW-1:0] req_csr_num,
  input  logic [XLEN-1:0]   req_rs1_value,
  input  logic [4:0]        req_rs1_idx,
  input  logic [4:0]        req_rd_idx,
  output logic [CSR_AW-1:0] csr_num,
  output logic              read_csr,
  input  logic [XLEN-1:0]   read_value,
  output logic              write_csr,
  output logic [2:0]        write_function,
  output logic [XLEN-1:0]   write_value,
  input  logic              csr_illegal,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [4:0]        rsp_rd_idx,
  output logic [XLEN-1:0]   rsp_rd_value,
  output logic              rsp_exception
);

  state_t              state_q, state_d;
  logic [2:0]          funct3_q;
  logic [CSR_AW-1:0]   csr_num_q;
  logic [XLEN-1:0]     rs1_value_q;
  logic [4:0]          rs1_idx_q;
  logic [4:0]          rd_idx_q;
  logic [XLEN-1:0]     old_q;
  logic                exc_q;

  logic                in_idle;
  logic                accept;
  logic                exc_set;
  logic                ro_violation;
  logic [2:0]          alu_funct3;
  logic [XLEN-1:0]     alu_rs1_value;
  logic [4:0]          alu_rs1_idx;
  logic [4:0]          alu_rd_idx;
  logic [XLEN-1:0]     alu_new_value;
  logic                alu_do_read;
  logic                alu_do_write;

  assign in_idle = (state_q == ST_IDLE);
  assign accept  = in_idle && req_valid && !flush;

  // In IDLE the ALU decodes the incoming request; afterwards it works on the
  // latched copy, so one instance serves both the decision and the datapath.
  assign alu_funct3    = in_idle ? req_funct3    : funct3_q;
  assign alu_rs1_value = in_idle ? req_rs1_value : rs1_value_q;
  assign alu_rs1_idx   = in_idle ? req_rs1_idx   : rs1_idx_q;
  assign alu_rd_idx    = in_idle ? req_rd_idx    : rd_idx_q;

  csr_rmw_alu #(.XLEN(XLEN)) u_rmw_alu (
    .funct3    (alu_funct3),
    .rs1_value (alu_rs1_value),
    .rs1_idx   (alu_rs1_idx),
    .rd_idx    (alu_rd_idx),
    .old_value (old_q),
    .new_value (alu_new_value),
    .do_read   (alu_do_read),
    .do_write  (alu_do_write)
  );

`ifdef CSR_ACCESS_ROCHECK_EN
  assign ro_violation = alu_do_write && (req_csr_num[CSR_AW-1 -: 2] == 2'b11);
`else
  assign ro_violation = 1'b0;
`endif

  // State register plus request/result capture; reset dominates flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      funct3_q    <= '0;
      csr_num_q   <= '0;
      rs1_value_q <= '0;
      rs1_idx_q   <= '0;
      rd_idx_q    <= '0;
      old_q       <= '0;
      exc_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q    <= req_funct3;
        csr_num_q   <= req_csr_num;
        rs1_value_q <= req_rs1_value;
        rs1_idx_q   <= req_rs1_idx;
        rd_idx_q    <= req_rd_idx;
        old_q       <= '0;
        exc_q       <= exc_set;
      end else begin
        if ((state_q == ST_READ) && !flush) begin
          old_q <= read_value;
        end
        if (exc_set && !flush) begin
          exc_q <= 1'b1;
        end
      end
    end
  end

  // Next-state and strobe decode; flush gates every strobe and returns to IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    read_csr  = 1'b0;
    write_csr = 1'b0;
    rsp_valid = 1'b0;
    exc_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = !flush;
        if (accept) begin
          if (f3_is_illegal(req_funct3) || ro_violation) begin
            exc_set = 1'b1;
            state_d = ST_RESP;
          end else if (alu_do_read) begin
            state_d = ST_READ;
          end else if (alu_do_write) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_READ: begin
        read_csr = !flush;
        if (csr_illegal) begin
          exc_set = 1'b1;
          state_d = ST_RESP;
        end else if (alu_do_write) begin
          state_d = ST_WRITE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        write_csr = !flush;
        exc_set   = csr_illegal;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = !flush;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  // Data outputs: write data only shown during WRITE, rd value zeroed on exception.
  always_comb begin
    csr_num        = csr_num_q;
    write_function = funct3_q;
    write_value    = (state_q == ST_WRITE) ? alu_new_value : '0;
    rsp_rd_idx     = rd_idx_q;
    rsp_rd_value   = ((state_q == ST_RESP) && !exc_q) ? old_q : '0;
    rsp_exception  = (state_q == ST_RESP) && exc_q;
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: a transaction-level model predicts
// the strobe/response sequence for each accepted request and is compared
// against the DUT every cycle; directed cases pin the model with literals.
module tb_csr_access_unit;

  localparam int PH_IDLE  = 0;
  localparam int PH_READ  = 1;
  localparam int PH_WRITE = 2;
  localparam int PH_RESP  = 3;

`ifdef CSR_ACCESS_ROCHECK_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, flush, req_valid, rsp_ready;
  logic        req_ready, read_csr, write_csr, rsp_valid, rsp_exception, csr_illegal;
  logic [2:0]  req_funct3, write_function;
  logic [11:0] req_csr_num, csr_num;
  logic [31:0] req_rs1_value, read_value, write_value, rsp_rd_value;
  logic [4:0]  req_rs1_idx, req_rd_idx, rsp_rd_idx;

  logic [31:0] csr_mem [4096];
  logic [11:0] csr_list [8] = '{12'h300, 12'h340, 12'h341, 12'hC00,
                                12'hC01, 12'h3EE, 12'h7C0, 12'hF11};

  int checks = 0;
  int errors = 0;

  // model state
  int          phq[$];
  logic [11:0] exp_csr;
  logic [2:0]  exp_f3;
  logic [31:0] exp_wval, exp_rdv;
  logic [4:0]  exp_rd_idx;
  logic        exp_exc;

  // observations
  logic        obs_req_ready, obs_read_csr, obs_write_csr, obs_rsp_valid, obs_rsp_exc;
  logic [11:0] obs_csr_num;
  logic [2:0]  obs_wfn;
  logic [31:0] obs_wval, obs_write_value, obs_rsp_rd_value;
  logic [4:0]  obs_rsp_rd_idx;
  logic [2:0]  obs_write_function;
  int          lat_ctr, rsp_lat, obs_reads, obs_writes;
  logic [31:0] rsp_rdv;
  logic        rsp_exc;

  always #5 clock = ~clock;

  function automatic logic csr_bad(input logic [11:0] n, input logic wr);
    return (n[7:0] == 8'hEE) || (wr && (n[11:10] == 2'b11));
  endfunction

  // csr block stand-in: combinational read data and illegal flag
  assign read_value  = csr_mem[csr_num];
  assign csr_illegal = csr_bad(csr_num, write_csr);

  csr_access_unit #(.XLEN(32), .CSR_AW(12)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr_num(req_csr_num), .req_rs1_value(req_rs1_value),
    .req_rs1_idx(req_rs1_idx), .req_rd_idx(req_rd_idx),
    .csr_num(csr_num), .read_csr(read_csr), .read_value(read_value),
    .write_csr(write_csr), .write_function(write_function), .write_value(write_value),
    .csr_illegal(csr_illegal), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd_idx(rsp_rd_idx), .rsp_rd_value(rsp_rd_value), .rsp_exception(rsp_exception)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Build the expected access sequence for a newly accepted request.
  task automatic model_accept();
    logic        swap, dr, dw;
    logic [31:0] opnd, old;
    swap = (req_funct3[1:0] == 2'b01);
    dr   = !(swap && (req_rd_idx == 5'd0));
    dw   = swap || (req_rs1_idx != 5'd0);
    opnd = req_funct3[2] ? {27'd0, req_rs1_idx} : req_rs1_value;
    exp_csr    = req_csr_num;
    exp_f3     = req_funct3;
    exp_rd_idx = req_rd_idx;
    exp_exc    = 1'b0;
    exp_wval   = 32'd0;
    old        = 32'd0;
    if ((req_funct3[1:0] == 2'b00) || (RO_EN && dw && (req_csr_num[11:10] == 2'b11))) begin
      exp_exc = 1'b1;
    end else begin
      if (dr) begin
        phq.push_back(PH_READ);
        if (csr_bad(req_csr_num, 1'b0)) exp_exc = 1'b1;
        else old = csr_mem[req_csr_num];
      end
      if (!exp_exc && dw) begin
        phq.push_back(PH_WRITE);
        if (csr_bad(req_csr_num, 1'b1)) exp_exc = 1'b1;
      end
      case (req_funct3[1:0])
        2'b01:   exp_wval = opnd;
        2'b10:   exp_wval = old | opnd;
        default: exp_wval = old & ~opnd;
      endcase
    end
    exp_rdv = exp_exc ? 32'd0 : old;
    phq.push_back(PH_RESP);
  endtask

  // Advance the model at the active edge using the inputs present at that edge.
  task automatic model_step();
    if (reset || flush) begin
      phq.delete();
    end else if (phq.size() == 0) begin
      if (req_valid) model_accept();
    end else begin
      case (phq[0])
        PH_READ:  void'(phq.pop_front());
        PH_WRITE: begin
          if (!csr_bad(exp_csr, 1'b1)) csr_mem[exp_csr] = exp_wval;
          void'(phq.pop_front());
        end
        default:  if (rsp_ready) void'(phq.pop_front());
      endcase
    end
  endtask

  task automatic compare();
    int ph;
    ph = (phq.size() == 0) ? PH_IDLE : phq[0];
    obs_req_ready      = req_ready;
    obs_read_csr       = read_csr;
    obs_write_csr      = write_csr;
    obs_rsp_valid      = rsp_valid;
    obs_rsp_exc        = rsp_exception;
    obs_csr_num        = csr_num;
    obs_write_value    = write_value;
    obs_write_function = write_function;
    obs_rsp_rd_value   = rsp_rd_value;
    obs_rsp_rd_idx     = rsp_rd_idx;
    chk("req_ready", req_ready, (ph == PH_IDLE) && !flush);
    chk("read_csr",  read_csr,  (ph == PH_READ) && !flush);
    chk("write_csr", write_csr, (ph == PH_WRITE) && !flush);
    chk("rsp_valid", rsp_valid, (ph == PH_RESP) && !flush);
    if ((ph == PH_READ) && !flush) chk("read_csr_num", csr_num, exp_csr);
    if ((ph == PH_WRITE) && !flush) begin
      chk("write_csr_num", csr_num, exp_csr);
      chk("write_function", write_function, exp_f3);
      chk("write_value", write_value, exp_wval);
    end
    if ((ph == PH_RESP) && !flush) begin
      chk("rsp_rd_idx", rsp_rd_idx, exp_rd_idx);
      chk("rsp_rd_value", rsp_rd_value, exp_rdv);
      chk("rsp_exception", rsp_exception, exp_exc);
    end
    lat_ctr++;
    if (rsp_valid && (rsp_lat < 0)) begin
      rsp_lat = lat_ctr;
      rsp_rdv = rsp_rd_value;
      rsp_exc = rsp_exception;
    end
    if (read_csr) obs_reads++;
    if (write_csr) begin
      obs_writes++;
      obs_wval = write_value;
      obs_wfn  = write_function;
    end
  endtask

  // One clock: compare on the falling edge, update model on the rising edge.
  task automatic cycle();
    @(negedge clock);
    compare();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) cycle();
    rsp_ready = 1'b0;
  endtask

  task automatic directed(input string nm, input logic [2:0] f3, input logic [11:0] csr,
                          input logic [31:0] rs1v, input logic [4:0] rs1i, input logic [4:0] rd,
                          input int e_lat, input int e_reads, input int e_writes,
                          input logic [31:0] e_wval, input logic [31:0] e_rdv,
                          input logic e_exc, input int hold);
    int guard;
    req_valid     = 1'b1;
    req_funct3    = f3;
    req_csr_num   = csr;
    req_rs1_value = rs1v;
    req_rs1_idx   = rs1i;
    req_rd_idx    = rd;
    rsp_ready     = 1'b0;
    cycle();
    req_valid  = 1'b0;
    lat_ctr    = 0;
    rsp_lat    = -1;
    obs_reads  = 0;
    obs_writes = 0;
    obs_wval   = 32'd0;
    obs_wfn    = 3'd0;
    guard      = 0;
    while ((rsp_lat < 0) && (guard < 8)) begin
      cycle();
      guard++;
    end
    repeat (hold) cycle();
    if (hold > 0) begin
      chk({nm, "_hold_req_ready"}, obs_req_ready, 1'b0);
      chk({nm, "_hold_rsp_valid"}, obs_rsp_valid, 1'b1);
      chk({nm, "_hold_rsp_exc"}, obs_rsp_exc, e_exc);
    end
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    chk({nm, "_latency"}, rsp_lat, e_lat);
    chk({nm, "_reads"}, obs_reads, e_reads);
    chk({nm, "_writes"}, obs_writes, e_writes);
    chk({nm, "_rd_value"}, rsp_rdv, e_rdv);
    chk({nm, "_exception"}, rsp_exc, e_exc);
    if (e_writes > 0) begin
      chk({nm, "_write_value"}, obs_wval, e_wval);
      chk({nm, "_write_function"}, obs_wfn, f3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = $urandom;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_funct3 = 3'd0; req_csr_num = 12'd0; req_rs1_value = 32'd0;
    req_rs1_idx = 5'd0; req_rd_idx = 5'd0;
    lat_ctr = 0; rsp_lat = -1; obs_reads = 0; obs_writes = 0;

    // reset values
    cycle();
    cycle();
    chk("reset_req_ready", obs_req_ready, 1'b1);
    chk("reset_read_csr", obs_read_csr, 1'b0);
    chk("reset_write_csr", obs_write_csr, 1'b0);
    chk("reset_rsp_valid", obs_rsp_valid, 1'b0);
    chk("reset_rsp_exc", obs_rsp_exc, 1'b0);
    chk("reset_csr_num", obs_csr_num, 12'd0);
    chk("reset_write_value", obs_write_value, 32'd0);
    chk("reset_rd_value", obs_rsp_rd_value, 32'd0);
    chk("reset_rd_idx", obs_rsp_rd_idx, 5'd0);
    reset = 1'b0;
    drain();

    csr_mem[12'hC00] = 32'h1234;
    directed("csrrs_ro", 3'b010, 12'hC00, 32'hDEAD_BEEF, 5'd0, 5'd5,
             2, 1, 0, 32'd0, 32'h1234, 1'b0, 0);
    csr_mem[12'h340] = 32'hFF;
    directed("csrrc", 3'b011, 12'h340, 32'h0F, 5'd7, 5'd3,
             3, 1, 1, 32'hF0, 32'hFF, 1'b0, 0);
    directed("csrrwi", 3'b101, 12'h340, 32'hFFFF_FFFF, 5'd7, 5'd0,
             2, 0, 1, 32'h7, 32'd0, 1'b0, 0);
    chk("csrrwi_stored", csr_mem[12'h340], 32'h7);
`ifdef CSR_ACCESS_ROCHECK_EN
    directed("csrrw_ro", 3'b001, 12'hC01, 32'h1, 5'd9, 5'd4,
             1, 0, 0, 32'd0, 32'd0, 1'b1, 0);
`else
    directed("csrrw_ro", 3'b001, 12'hC01, 32'h1, 5'd9, 5'd4,
             3, 1, 1, 32'h1, 32'd0, 1'b1, 0);
`endif
    directed("f3_100", 3'b100, 12'h300, 32'h55, 5'd2, 5'd6,
             1, 0, 0, 32'd0, 32'd0, 1'b1, 4);

    // flush in the WRITE cycle of a CSRRW
    drain();
    req_valid = 1'b1; req_funct3 = 3'b001; req_csr_num = 12'h341;
    req_rs1_value = 32'hABCD; req_rs1_idx = 5'd3; req_rd_idx = 5'd2;
    cycle();
    req_valid = 1'b0;
    cycle();
    flush = 1'b1;
    cycle();
    chk("flush_write_csr", obs_write_csr, 1'b0);
    flush = 1'b0;
    rsp_ready = 1'b0;
    cycle();
    chk("flush_req_ready", obs_req_ready, 1'b1);
    chk("flush_rsp_valid", obs_rsp_valid, 1'b0);

    // reset in the READ cycle
    req_valid = 1'b1; req_funct3 = 3'b010; req_csr_num = 12'h300;
    req_rs1_idx = 5'd0; req_rd_idx = 5'd1;
    cycle();
    req_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("midrst_req_ready", obs_req_ready, 1'b1);
    chk("midrst_read_csr", obs_read_csr, 1'b0);
    chk("midrst_write_csr", obs_write_csr, 1'b0);
    chk("midrst_rsp_valid", obs_rsp_valid, 1'b0);
    chk("midrst_csr_num", obs_csr_num, 12'd0);
    chk("midrst_write_function", obs_write_function, 3'd0);
    chk("midrst_rd_idx", obs_rsp_rd_idx, 5'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_valid     = ($urandom_range(0, 2) != 0);
      req_funct3    = 3'($urandom_range(0, 7));
      req_csr_num   = csr_list[$urandom_range(0, 7)];
      req_rs1_value = $urandom;
      req_rs1_idx   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      req_rd_idx    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rsp_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 24) == 0);
      reset         = ($urandom_range(0, 149) == 0);
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
